axi_rd_arbiter: RTL and testbench

// Read-side scheduler in front of the AXI bridge AR/R channels. Shares one AR channel between the

---
 rtl/axi_rd_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Shares one AR channel between the inst-fetch and data-load requesters and routes R beats back by rid.
// Latency: addr_ok is combinational in the grant cycle; arvalid rises 1 cycle later; R data passes through combinationally.
// Backpressure: the AR payload stays frozen until arready. Requests stall at MAX_OUTS outstanding or on a RAW hazard. rready is always 1.
module axi_rd_arbiter #(
    parameter int MAX_OUTS   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [1:0]  data_size,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    input  logic        wr_busy,
    input  logic [31:0] wr_addr,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic        rsp_err
);

    localparam int CW = $clog2(MAX_OUTS + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        IDLE    = 1'b0,
        AR_WAIT = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   inst_cnt;
    logic [CW-1:0]   data_cnt;
    logic [SW-1:0]   starve_cnt;

    logic            raw_hazard;
    logic            inst_elig;
    logic            data_elig;
    logic            starved;
    logic            grant_inst;
    logic            grant_data;
    logic [2:0]      data_arsize;
    logic            inst_rsp;
    logic            data_rsp;
    logic            bad_rsp;
    logic            unused_wr_lsb;

    assign unused_wr_lsb = ^wr_addr[1:0];

    // A data read waits while a write to the same 32-bit word is still in flight.
    assign raw_hazard = wr_busy && (data_addr[31:2] == wr_addr[31:2]);
    assign inst_elig  = inst_req && (inst_cnt < CW'(MAX_OUTS));
    assign data_elig  = data_req && (data_cnt < CW'(MAX_OUTS)) && !raw_hazard;
    assign starved    = (starve_cnt >= SW'(STARVE_MAX));

    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (state_q == IDLE) begin
            grant_inst = inst_elig && (!data_elig || starved);
            grant_data = data_elig && !grant_inst;
        end
    end

    always_comb begin
        case (data_size)
            2'd0:    data_arsize = 3'd0;
            2'd1:    data_arsize = 3'd1;
            default: data_arsize = 3'd2;
        endcase
    end

    // FSM: state register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_inst || grant_data) state_d = AR_WAIT;
            AR_WAIT: if (arready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        arvalid      = (state_q == AR_WAIT);
        inst_addr_ok = grant_inst;
        data_addr_ok = grant_data;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            arid   <= 4'd0;
            araddr <= 32'd0;
            arsize <= 3'd0;
        end else if (grant_inst) begin
            arid   <= 4'd0;
            araddr <= inst_addr;
            arsize <= 3'd2;
        end else if (grant_data) begin
            arid   <= 4'd1;
            araddr <= data_addr;
            arsize <= data_arsize;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            starve_cnt <= '0;
        end else if (grant_inst) begin
            starve_cnt <= '0;
        end else if (grant_data && inst_elig && !starved) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // A beat is only routed when its requester actually has a read outstanding.
    assign inst_rsp = rvalid && (rid == 4'd0) && (inst_cnt != '0);
    assign data_rsp = rvalid && (rid == 4'd1) && (data_cnt != '0);
    assign bad_rsp  = rvalid && !inst_rsp && !data_rsp;

    assign inst_data_ok = inst_rsp;
    assign data_data_ok = data_rsp;
    assign inst_rdata   = inst_rsp ? rdata : 32'd0;
    assign data_rdata   = data_rsp ? rdata : 32'd0;
    assign rready       = 1'b1;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            inst_cnt <= '0;
            data_cnt <= '0;
        end else begin
            case ({grant_inst, inst_rsp})
                2'b10:   inst_cnt <= inst_cnt + CW'(1);
                2'b01:   inst_cnt <= inst_cnt - CW'(1);
                default: inst_cnt <= inst_cnt;
            endcase
            case ({grant_data, data_rsp})
                2'b10:   data_cnt <= data_cnt + CW'(1);
                2'b01:   data_cnt <= data_cnt - CW'(1);
                default: data_cnt <= data_cnt;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rsp_err <= 1'b0;
        end else if (bad_rsp) begin
            rsp_err <= 1'b1;
        end
    end

    a_single_grant: assert property (@(posedge aclk) disable iff (!aresetn)
        !(inst_addr_ok && data_addr_ok));

    a_ar_hold: assert property (@(posedge aclk) disable iff (!aresetn)
        (arvalid && !arready) |=> (arvalid && $stable(araddr) && $stable(arid) && $stable(arsize)));

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Random traffic against a transaction-level model of the read scheduler, plus directed error-beat cases.
module tb_axi_rd_arbiter;

    localparam int MAX_OUTS   = 2;
    localparam int STARVE_MAX = 4;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [31:0] data_addr;
    logic [1:0]  data_size;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        wr_busy;
    logic [31:0] wr_addr;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rvalid, rready, rsp_err;

    axi_rd_arbiter #(.MAX_OUTS(MAX_OUTS), .STARVE_MAX(STARVE_MAX)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .wr_busy(wr_busy), .wr_addr(wr_addr),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready), .rsp_err(rsp_err)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
    } ar_t;

    int errors = 0;
    int checks = 0;

    // Reference model state: outstanding reads per requester, AR in flight, starvation tally.
    int          m_cnt0, m_cnt1, m_starve;
    bit          m_pend, m_err;
    logic [3:0]  m_arid;
    logic [31:0] m_araddr;
    logic [2:0]  m_arsize;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    ar_t         slv_q[$];
    bit          inst_acc, data_acc;

    int p_req, p_ardy, p_r, p_wr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h3C5A_96E1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor and scoreboard, sampled mid-cycle.
    always @(negedge aclk) begin
        bit          ie, de, haz, win_i, win_d, ok0, ok1;
        int          inc0, inc1, dec0, dec1;
        logic [31:0] e;
        logic [2:0]  sz;
        ar_t         t;
        inc0 = 0; inc1 = 0; dec0 = 0; dec1 = 0;
        if (!aresetn) begin
            m_cnt0 = 0; m_cnt1 = 0; m_starve = 0; m_pend = 0; m_err = 0;
            exp_q0.delete(); exp_q1.delete(); slv_q.delete();
        end else begin
            chk("rsp_err", 32'(rsp_err), 32'(m_err));
            chk("arvalid", 32'(arvalid), 32'(m_pend));
            chk("rready", 32'(rready), 32'd1);
            if (m_pend) begin
                chk("arid_hold", 32'(arid), 32'(m_arid));
                chk("araddr_hold", araddr, m_araddr);
                chk("arsize_hold", 32'(arsize), 32'(m_arsize));
                chk("addr_ok_during_wait", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
                if (arready) begin
                    t.id = arid;
                    t.addr = araddr;
                    slv_q.push_back(t);
                    m_pend = 0;
                end
            end else begin
                haz   = wr_busy && (data_addr[31:2] == wr_addr[31:2]);
                ie    = inst_req && (m_cnt0 < MAX_OUTS);
                de    = data_req && (m_cnt1 < MAX_OUTS) && !haz;
                win_i = ie && (!de || m_starve >= STARVE_MAX);
                win_d = de && !win_i;
                chk("inst_addr_ok", 32'(inst_addr_ok), 32'(win_i));
                chk("data_addr_ok", 32'(data_addr_ok), 32'(win_d));
                if (win_i) begin
                    m_pend = 1; m_arid = 4'd0; m_araddr = inst_addr; m_arsize = 3'd2;
                    exp_q0.push_back(memf(inst_addr));
                    inc0 = 1;
                    m_starve = 0;
                end
                if (win_d) begin
                    sz = (data_size == 2'd0) ? 3'd0 : (data_size == 2'd1) ? 3'd1 : 3'd2;
                    m_pend = 1; m_arid = 4'd1; m_araddr = data_addr; m_arsize = sz;
                    exp_q1.push_back(memf(data_addr));
                    inc1 = 1;
                    if (ie) m_starve++;
                end
            end
            if (inst_addr_ok) inst_acc = 1;
            if (data_addr_ok) data_acc = 1;

            ok0 = rvalid && (rid == 4'd0) && (m_cnt0 > 0);
            ok1 = rvalid && (rid == 4'd1) && (m_cnt1 > 0);
            chk("inst_data_ok", 32'(inst_data_ok), 32'(ok0));
            chk("data_data_ok", 32'(data_data_ok), 32'(ok1));
            if (ok0) begin
                e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 32'hBAD0_0000;
                chk("inst_rdata", inst_rdata, e);
                dec0 = 1;
            end else begin
                chk("inst_rdata_idle", inst_rdata, 32'd0);
            end
            if (ok1) begin
                e = (exp_q1.size() > 0) ? exp_q1.pop_front() : 32'hBAD0_0001;
                chk("data_rdata", data_rdata, e);
                dec1 = 1;
            end else begin
                chk("data_rdata_idle", data_rdata, 32'd0);
            end
            if (rvalid && !ok0 && !ok1) m_err = 1;
            m_cnt0 = m_cnt0 + inc0 - dec0;
            m_cnt1 = m_cnt1 + inc1 - dec1;
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive_random();
        ar_t t;
        if (inst_acc) begin inst_req = 1'b0; inst_acc = 0; end
        if (data_acc) begin data_req = 1'b0; data_acc = 0; end
        if (!inst_req && ($urandom % 100) < p_req) begin
            inst_req  = 1'b1;
            inst_addr = 32'h1C00_0000 | ($urandom & 32'h0000_0FFC);
        end
        if (!data_req && ($urandom % 100) < p_req) begin
            data_req  = 1'b1;
            data_addr = {24'h0, 8'($urandom)};
            data_size = 2'($urandom);
        end
        wr_busy = ($urandom % 100) < p_wr;
        wr_addr = ($urandom % 2 == 0) ? {data_addr[31:2], 2'($urandom)} : {24'h0, 8'($urandom)};
        arready = ($urandom % 100) < p_ardy;
        if (slv_q.size() > 0 && ($urandom % 100) < p_r) begin
            t = slv_q.pop_front();
            rvalid = 1'b1;
            rid    = t.id;
            rdata  = memf(t.addr);
        end else begin
            rvalid = 1'b0;
            rid    = 4'($urandom);
            rdata  = $urandom;
        end
    endtask

    task automatic do_reset(input int cycles);
        step();
        aresetn  = 1'b0;
        inst_req = 1'b0;
        data_req = 1'b0;
        rvalid   = 1'b0;
        inst_acc = 0;
        data_acc = 0;
        repeat (cycles) step();
        aresetn = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            drive_random();
        end
    endtask

    initial begin
        aresetn = 1'b0; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_addr = '0;
        data_size = '0; wr_busy = 1'b0; wr_addr = '0; arready = 1'b0; rid = '0;
        rdata = '0; rvalid = 1'b0; inst_acc = 0; data_acc = 0;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;

        // Saturated requests with prompt responses: exercises the starvation window.
        p_req = 100; p_ardy = 100; p_r = 80; p_wr = 0;
        run(400);
        // Mixed traffic with RAW hazards and AR backpressure.
        p_req = 60; p_ardy = 50; p_r = 40; p_wr = 40;
        run(1500);
        // Long AR stall, then resume.
        p_req = 100; p_ardy = 0;
        run(12);
        p_ardy = 60;
        run(300);
        // Reset with reads in flight.
        do_reset(2);
        p_req = 70; p_ardy = 70; p_r = 50; p_wr = 30;
        run(800);

        // Drain: no new requests, slave answers everything.
        p_req = 0; p_ardy = 100; p_r = 100; p_wr = 0;
        for (int i = 0; i < 300; i++) begin
            if (exp_q0.size() == 0 && exp_q1.size() == 0 && slv_q.size() == 0 && !m_pend && !inst_req && !data_req)
                break;
            step();
            drive_random();
        end
        chk("drain_inst_pending", exp_q0.size(), 32'd0);
        chk("drain_data_pending", exp_q1.size(), 32'd0);
        chk("drain_ar_pending", 32'(m_pend), 32'd0);
        chk("no_err_before_inject", 32'(m_err), 32'd0);

        // Beat for rid 0 with nothing outstanding: no data_ok, sticky error.
        step();
        rvalid = 1'b1; rid = 4'd0; rdata = 32'hDEAD_BEEF; arready = 1'b0;
        step();
        rvalid = 1'b0;
        repeat (3) step();
        chk("err_sticky_after_stray", 32'(m_err), 32'd1);

        // Reset clears the flag; an unknown rid sets it again.
        do_reset(2);
        step();
        rvalid = 1'b1; rid = 4'd9; rdata = 32'h1234_5678;
        step();
        rvalid = 1'b0;
        repeat (3) step();
        chk("err_after_bad_rid", 32'(m_err), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
